// File: rtl/alu_instr_sequencer_if.sv
// Handshake bundle between the instruction sequencer (master) and the ALU (slave):
// operand/opcode issue on valid/ready, result returned on a single strobe.
interface alu_instr_sequencer_if;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] opcode;
  logic       issue_valid;
  logic       issue_ready;
  logic       result_valid;
  logic [7:0] result_in;
  logic       carry_in;

  modport master (
    output a, b, opcode, issue_valid,
    input  issue_ready, result_valid, result_in, carry_in
  );

  modport slave (
    input  a, b, opcode, issue_valid,
    output issue_ready, result_valid, result_in, carry_in
  );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Loadable-program instruction sequencer for the 8-bit ALU; captures {err, carry, result} per step.
// Optional result timeout is compiled in with `define ALU_SEQ_TIMEOUT_EN.
module alu_instr_sequencer #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        prog_we,
  input  logic [AW-1:0]               prog_addr,
  input  logic [18:0]                 prog_wdata,
  input  logic                        start,
  input  logic [AW:0]                 len,
  alu_instr_sequencer_if.master       alu,
  input  logic [AW-1:0]               res_rd_addr,
  output logic [9:0]                  res_rd_data,
  output logic [AW-1:0]               pc,
  output logic                        busy,
  output logic                        done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  if (DEPTH != (1 << AW) || DEPTH < 2 || DEPTH > 16 || TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_param
    $error("alu_instr_sequencer: inconsistent DEPTH/AW/TIMEOUT");
  end

  logic [2:0]    r_state;
  logic [AW-1:0] r_pc;
  logic [AW:0]   r_len;
  logic [7:0]    r_a;
  logic [7:0]    r_b;
  logic [2:0]    r_opcode;
  logic [18:0]   r_prog_mem [DEPTH];
  logic [9:0]    r_res_buf  [DEPTH];

  logic          w_idle;
  logic [AW:0]   w_len_clamped;
  logic          w_last;
  logic          w_timeout;
  logic          w_res_take;
  logic [9:0]    w_res_word;

  assign w_idle        = (r_state == S_IDLE);
  assign w_len_clamped = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
  assign w_last        = ({1'b0, r_pc} == (r_len - (AW+1)'(1)));

`ifdef ALU_SEQ_TIMEOUT_EN
  logic [3:0] r_wait_cnt;

  // Counter is zero on the first WAIT cycle, so the timeout lands on WAIT cycle TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_wait_cnt <= 4'd0;
    else if (r_state != S_WAIT)    r_wait_cnt <= 4'd0;
    else if (!w_res_take)          r_wait_cnt <= r_wait_cnt + 4'd1;
  end

  assign w_timeout  = (r_wait_cnt == 4'(TIMEOUT - 1));
  assign w_res_word = alu.result_valid ? {1'b0, alu.carry_in, alu.result_in} : 10'h200;
`else
  assign w_timeout  = 1'b0;
  assign w_res_word = {1'b0, alu.carry_in, alu.result_in};
`endif

  assign w_res_take = alu.result_valid | w_timeout;

  // NOTE: every clocked block uses non-blocking assignments so all registers update
  // from the same pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_len    <= '0;
      r_a      <= 8'd0;
      r_b      <= 8'd0;
      r_opcode <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (len == '0) begin
              r_state <= S_DONE;
            end else begin
              r_len   <= w_len_clamped;
              r_pc    <= '0;
              r_state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          {r_opcode, r_a, r_b} <= r_prog_mem[r_pc];
          r_state              <= S_ISSUE;
        end
        S_ISSUE: begin
          if (alu.issue_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_res_take) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_pc    <= r_pc + AW'(1);
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the program store is deliberately left out of reset so it survives a mid-run
  // reset and maps onto plain RAM; only the result buffer is cleared.
  always_ff @(posedge clk) begin
    if (w_idle && prog_we) r_prog_mem[prog_addr] <= prog_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_res_buf[i] <= 10'd0;
    end else if (r_state == S_WAIT && w_res_take) begin
      r_res_buf[r_pc] <= w_res_word;
    end
  end

  assign alu.a           = r_a;
  assign alu.b           = r_b;
  assign alu.opcode      = r_opcode;
  assign alu.issue_valid = (r_state == S_ISSUE);

  assign res_rd_data = r_res_buf[res_rd_addr];
  assign pc          = r_pc;
  assign busy        = !w_idle;
  assign done        = (r_state == S_DONE);

endmodule
